// File: rtl/mem_stage_pkg.sv
// Shared types and constants for the memory stage: FSM states, memory op kinds, beat geometry.
package mem_stage_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        OP_NONE  = 2'd0,
        OP_LOAD  = 2'd1,
        OP_STORE = 2'd2
    } op_t;

    localparam int BEATS      = 4;
    localparam int BEAT_BYTES = 4;

endpackage

// File: rtl/beat_assembler.sv
// Lane steering between the 32-bit bus and the 128-bit vector: inserts a load word at the
// current beat index and selects the store word for the current beat.
module beat_assembler #(
    parameter int DATA_W = 128,
    parameter int BUS_W  = 32
) (
    input  logic [DATA_W-1:0] lanes,
    input  logic [1:0]        beat,
    input  logic [BUS_W-1:0]  rdata,
    input  logic [DATA_W-1:0] store_data,
    output logic [DATA_W-1:0] lanes_next,
    output logic [BUS_W-1:0]  wdata
);

    always_comb begin
        lanes_next = lanes;
        lanes_next[BUS_W*int'(beat) +: BUS_W] = rdata;
    end

    assign wdata = store_data[BUS_W*int'(beat) +: BUS_W];

endmodule

// File: rtl/memory_stage_unit.sv
// Memory pipeline stage: scalar or 4-beat vector load/store over a 32-bit ack bus, stalling
// upstream while in flight. Optional bus-timeout abort is enabled by defining MEM_TIMEOUT_EN.
module memory_stage_unit
    import mem_stage_pkg::*;
#(
    parameter int DATA_W  = 128,
    parameter int BUS_W   = 32,
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              MemRd1,
    input  logic              MemWr1,
    input  logic              VF1,
    input  logic              RegWr1,
    input  logic [3:0]        R_V_dest1,
    input  logic [DATA_W-1:0] ALURES1,
    input  logic [DATA_W-1:0] R3_V3_2,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [BUS_W-1:0]  mem_wdata,
    input  logic              mem_ack,
    input  logic [BUS_W-1:0]  mem_rdata,
    output logic              Stall,
    output logic              VF2,
    output logic              RegWr2,
    output logic [3:0]        R_V_dest2,
    output logic [DATA_W-1:0] ResRV,
    output logic              MemErr
);

    if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_timeout_range
        $error("TIMEOUT must fit the 8-bit wait counter");
    end

    state_t              state, next_state;
    op_t                 op_q;
    logic                vf_q;
    logic                regwr_q;
    logic [3:0]          dest_q;
    logic [ADDR_W-1:0]   base_q;
    logic [DATA_W-1:0]   sdata_q;
    logic [DATA_W-1:0]   alu_q;
    logic [1:0]          beat_q;
    logic [DATA_W-1:0]   lanes_q;
    logic [DATA_W-1:0]   lanes_next;
    logic [BUS_W-1:0]    lane_wdata;
    logic [DATA_W-1:0]   load_result;
    logic                start;
    logic                is_last;
    logic                timeout_fire;

    beat_assembler #(.DATA_W(DATA_W), .BUS_W(BUS_W)) u_beat_assembler (
        .lanes      (lanes_q),
        .beat       (beat_q),
        .rdata      (mem_rdata),
        .store_data (sdata_q),
        .lanes_next (lanes_next),
        .wdata      (lane_wdata)
    );

    assign start   = MemRd1 | MemWr1;
    assign is_last = vf_q ? (beat_q == 2'(BEATS - 1)) : (beat_q == 2'd0);

    always_comb begin
        load_result = {{(DATA_W-BUS_W){1'b0}}, mem_rdata};
        if (vf_q) begin
            load_result = lanes_next;
        end
    end

    // Bus signals are decoded from registered state, so they stay stable until the ack edge.
    always_comb begin
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (state == ACCESS) begin
            mem_req   = 1'b1;
            mem_we    = (op_q == OP_STORE);
            mem_addr  = base_q + ADDR_W'(beat_q) * ADDR_W'(BEAT_BYTES);
            mem_wdata = lane_wdata;
        end
    end

    always_comb begin
        next_state = state;
        Stall      = 1'b0;
        case (state)
            IDLE: begin
                Stall = start;
                if (start) begin
                    next_state = ACCESS;
                end
            end
            ACCESS: begin
                Stall = 1'b1;
                if ((mem_ack && is_last) || timeout_fire) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            op_q      <= OP_NONE;
            vf_q      <= 1'b0;
            regwr_q   <= 1'b0;
            dest_q    <= '0;
            base_q    <= '0;
            sdata_q   <= '0;
            alu_q     <= '0;
            beat_q    <= '0;
            lanes_q   <= '0;
            VF2       <= 1'b0;
            RegWr2    <= 1'b0;
            R_V_dest2 <= '0;
            ResRV     <= '0;
        end else begin
            state <= next_state;
            case (state)
                IDLE: begin
                    if (start) begin
                        op_q    <= MemWr1 ? OP_STORE : OP_LOAD;
                        vf_q    <= VF1;
                        regwr_q <= RegWr1;
                        dest_q  <= R_V_dest1;
                        base_q  <= ALURES1[ADDR_W-1:0];
                        sdata_q <= R3_V3_2;
                        alu_q   <= ALURES1;
                        beat_q  <= '0;
                        RegWr2  <= 1'b0;
                    end else begin
                        VF2       <= VF1;
                        RegWr2    <= RegWr1;
                        R_V_dest2 <= R_V_dest1;
                        ResRV     <= ALURES1;
                    end
                end
                ACCESS: begin
                    // Bubble while in flight so forwarding never picks up an old result.
                    RegWr2 <= 1'b0;
                    if (mem_ack) begin
                        beat_q <= beat_q + 2'd1;
                        if (op_q == OP_LOAD) begin
                            lanes_q <= lanes_next;
                        end
                        if (is_last) begin
                            VF2       <= vf_q;
                            R_V_dest2 <= dest_q;
                            RegWr2    <= (op_q == OP_LOAD) && regwr_q;
                            ResRV     <= (op_q == OP_LOAD) ? load_result : alu_q;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

`ifdef MEM_TIMEOUT_EN
    logic [7:0] wait_cnt;
    logic       mem_err_q;

    assign timeout_fire = (state == ACCESS) && !mem_ack && (wait_cnt == 8'(TIMEOUT - 1));
    assign MemErr       = mem_err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt  <= '0;
            mem_err_q <= 1'b0;
        end else begin
            if (state != ACCESS || mem_ack) begin
                wait_cnt <= '0;
            end else begin
                wait_cnt <= wait_cnt + 8'd1;
            end
            if (timeout_fire) begin
                mem_err_q <= 1'b1;
            end
        end
    end
`else
    assign timeout_fire = 1'b0;
    assign MemErr       = 1'b0;
`endif

endmodule

// File: doc/memory_stage_unit.md
Name: memory_stage_unit

Overview:
- Pipeline stage that consumes the execute-stage results: ALU result/address, store data, and destination tags.
- Performs scalar (1-beat) or 128-bit vector (4-beat) load/store over a 32-bit handshaked memory bus.
- Stalls upstream while an access is in flight.
- Registers the stage result (VF2, R_V_dest2, ResRV) that feeds writeback and the execute-stage forwarding path.

Parameters:
- DATA_W, 128, vector register width.
- BUS_W, 32, memory bus word width; BEATS = DATA_W/BUS_W = 4.
- ADDR_W, 32, byte address width.
- TIMEOUT, 255, ack-wait limit in cycles; used only with MEM_TIMEOUT_EN.

Ports:
- clk  in  1  clock; single clock domain.
- rst  in  1  synchronous, active-high reset.
- MemRd1  in  1  load request from execute.
- MemWr1  in  1  store request from execute.
- VF1  in  1  1 = vector op, 0 = scalar.
- RegWr1  in  1  instruction writes a register.
- R_V_dest1  in  4  destination register index.
- ALURES1  in  128  ALU result; bits [31:0] are the byte address for memory ops.
- R3_V3_2  in  128  store data.
- mem_req  out  1  bus request.
- mem_we  out  1  1 = write beat.
- mem_addr  out  32  beat address.
- mem_wdata  out  32  write beat data.
- mem_ack  in  1  beat accepted / read data valid.
- mem_rdata  in  32  read beat data.
- Stall  out  1  hold upstream stages.
- VF2  out  1  registered vector flag.
- RegWr2  out  1  registered write enable.
- R_V_dest2  out  4  registered destination.
- ResRV  out  128  registered result.
- MemErr  out  1  sticky bus-timeout flag.

Behaviour:
- Reset (synchronous, active-high):
  - state = IDLE, beat = 0.
  - mem_req = mem_we = 0; mem_addr = mem_wdata = 0.
  - VF2 = RegWr2 = 0, R_V_dest2 = 0, ResRV = 0, MemErr = 0.
  - Reset mid-access aborts immediately: mem_req drops the next cycle, partial beats are discarded, and no output register update occurs.
- FSM states: IDLE, ACCESS, DONE.
- IDLE:
  - No memory op: the output register loads {VF1, RegWr1, R_V_dest1, ALURES1} every cycle. Non-memory instructions have latency 1.
  - MemRd1 or MemWr1 set: latch the op, base address, store data, and tags; beat = 0; go to ACCESS.
  - MemRd1 and MemWr1 both set: treated as a store.
- Stall = (IDLE & (MemRd1 | MemWr1)) | ACCESS; purely combinational. Upstream holds its inputs while Stall = 1.
- Output register during ACCESS: holds the previous value, except RegWr2 is forced to 0 (bubble) so forwarding never sees stale data.
- ACCESS bus drive:
  - mem_req = 1, mem_we = store.
  - mem_addr = base + 4*beat.
  - mem_wdata = store_data[32*beat +: 32].
  - mem_req, mem_addr and mem_wdata are held stable until mem_ack.
- ACCESS on mem_ack:
  - A load captures mem_rdata into lane[beat]; beat increments.
  - Last beat is beat = 3 for vector, beat = 0 for scalar.
  - On the last-beat ack edge:
    - Output register loads VF2 = VF, R_V_dest2 = dest, RegWr2 = load & RegWr.
    - ResRV = assembled lanes for a vector load; {96'h0, word} for a scalar load; the latched ALURES1 for a store.
    - mem_req drops; go to DONE.
- DONE (1 cycle):
  - Stall = 0, so upstream advances; the output register holds; go to IDLE.
  - Prevents re-issuing the same instruction.
- Latency: a vector load takes 4 acks + 1 cycle with zero-wait memory, so Stall is high for 5 cycles.
- Address arithmetic: modulo 2^32, so wrap-around at 0xFFFF_FFFC → 0x0000_0000 is legal.
- Beat order: lane 0 (bits [31:0]) first.

Optional Feature:
- MEM_TIMEOUT_EN defined:
  - An 8-bit wait counter clears on each ack.
  - Reaching TIMEOUT without mem_ack aborts the access: mem_req drops, MemErr is set (sticky until rst), the output register loads a bubble (RegWr2 = 0), and the FSM goes to DONE.
- Undefined: the FSM waits indefinitely for mem_ack and MemErr is tied to 0.

Decomposition:
- Package mem_stage_pkg holds:
  - the state enum (IDLE, ACCESS, DONE);
  - constants BEATS = 4 and BEAT_BYTES = 4;
  - the op typedef (OP_NONE, OP_LOAD, OP_STORE).
- One sub-module, beat_assembler:
  - writes a 32-bit lane into the 128-bit load buffer at the beat index;
  - selects the store lane for mem_wdata.

Test Plan:
- Non-memory pass-through: ALURES1 = 128'h1234, RegWr1 = 1, R_V_dest1 = 5 → next cycle ResRV = 128'h1234, RegWr2 = 1, R_V_dest2 = 5, Stall = 0 throughout.
- Vector load at 0x100, zero-wait ack, rdata = 0xA, 0xB, 0xC, 0xD:
  - mem_addr steps 0x100 / 0x104 / 0x108 / 0x10C;
  - ResRV = {0xD, 0xC, 0xB, 0xA};
  - Stall high for 5 cycles.
- Scalar store at 0x20, data 0xDEADBEEF, ack after 3 wait cycles:
  - mem_we = 1 and mem_wdata stable during the wait;
  - RegWr2 = 0 after completion.
- Simultaneous MemRd1 = MemWr1 = 1, vector: 4 write beats, no read capture.
- rst asserted after beat 2 of a vector load: mem_req = 0 next cycle, all outputs 0, FSM in IDLE; a new load then completes normally.
- MEM_TIMEOUT_EN build, mem_ack held 0: after 255 cycles MemErr = 1 and Stall drops; without the macro, Stall stays high.
